// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank
//   Bank of NUM_CH event counters plus one free-running cycle counter, with
//   freeze/clear/halt control and a one-cycle-latency registered read port.
//   Channel map (default): 0 inst, 1 icache_req, 2 icache_hit,
//   3 dcache_req, 4 dcache_hit; rd_sel == NUM_CH selects the cycle counter.
//
//   Optional build macro: PERF_OVF_STICKY_EN
//     defined   -> ovf[i] is a sticky overflow flag per counter
//                  (ovf[NUM_CH] is the cycle counter's flag)
//     undefined -> ovf is tied to zero and no overflow logic exists
//
//   Read handshake: rd_req is sampled on every rising edge with rd_sel. The
//   edge that samples rd_req=1 raises rd_valid for the following cycle and
//   loads rd_data with the selected counter value as it was before that
//   edge's update (rd_err=1, rd_data=0 if rd_sel is beyond the cycle
//   counter). There is no back-pressure; holding rd_req gives one result
//   per cycle. rd_data holds its last value whenever rd_valid is 0.
module perf_event_counter_bank #(
   parameter int NUM_CH   = 5,
   parameter int CNT_W    = 32,
   parameter int SATURATE = 0,
   parameter int SEL_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ev,
   input  logic              freeze,
   input  logic              clear,
   input  logic              halt,
   input  logic              rd_req,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_err,
   output logic              halted,
   output logic [NUM_CH:0]   ovf
);

   localparam int NC = NUM_CH + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FROZEN = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             count_en;
   logic [NC-1:0]    inc;
   logic [CNT_W-1:0] cnt_q [NC];
   logic [CNT_W-1:0] rd_mux;
   logic             rd_oor;

   // The cycle counter is simply a channel whose event fires every cycle.
   assign inc    = {1'b1, ev};
   assign halted = (state_q == ST_HALTED);

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and count enable; clear beats halt beats freeze beats counting.
   // The halt cycle itself still counts unless freeze is also high.
   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      if (clear) begin
         state_d = ST_RUN;
      end else begin
         count_en = !freeze && (state_q != ST_HALTED);
         case (state_q)
            ST_RUN: begin
               if (halt)        state_d = ST_HALTED;
               else if (freeze) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
               if (halt)         state_d = ST_HALTED;
               else if (!freeze) state_d = ST_RUN;
            end
            ST_HALTED: begin
               state_d = ST_HALTED;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // Counter bank: clear zeroes everything, otherwise increment on events,
   // either wrapping or sticking at the maximum value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      end else if (count_en) begin
         for (int i = 0; i < NC; i++) begin
            if (inc[i] && !((SATURATE != 0) && (cnt_q[i] == CNT_MAX))) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Read select mux; out-of-range selects return zero.
   always_comb begin
      rd_mux = '0;
      rd_oor = (rd_sel > SEL_W'(NUM_CH));
      for (int i = 0; i < NC; i++) begin
         if (rd_sel == SEL_W'(i)) rd_mux = cnt_q[i];
      end
   end

   // Registered read port; captures pre-update counter values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && rd_oor;
         if (rd_req) begin
            rd_data <= rd_oor ? '0 : rd_mux;
         end
      end
   end

`ifdef PERF_OVF_STICKY_EN
   logic [NC-1:0] ovf_q;
   logic [NC-1:0] ovf_hit;

   // A flag fires on the increment that wraps (wrap mode) or that first
   // lands on the maximum value (saturate mode).
   always_comb begin
      ovf_hit = '0;
      for (int i = 0; i < NC; i++) begin
         if (SATURATE != 0) begin
            ovf_hit[i] = count_en && inc[i] && (cnt_q[i] == (CNT_MAX - CNT_W'(1)));
         end else begin
            ovf_hit[i] = count_en && inc[i] && (cnt_q[i] == CNT_MAX);
         end
      end
   end

   // Sticky overflow flags, cleared only by clear or reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= '0;
      end else if (clear) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_q | ovf_hit;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = '0;
`endif

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// tb_perf_event_counter_bank
//   Directed test of perf_event_counter_bank: a default 32-bit wrap instance
//   plus two 4-bit instances (wrap and saturate) for the overflow corner.
module tb_perf_event_counter_bank;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (NUM_CH=5, CNT_W=32, SATURATE=0)
   logic        rst;
   logic [4:0]  ev;
   logic        freeze, clear, halt, rd_req;
   logic [2:0]  rd_sel;
   logic        rd_valid, rd_err, halted;
   logic [31:0] rd_data;
   logic [5:0]  ovf;

   // small instances share inputs (CNT_W=4)
   logic        s_rst;
   logic [4:0]  s_ev;
   logic        s_freeze, s_req;
   logic [2:0]  s_sel;
   logic        w_valid, w_err, w_halted, t_valid, t_err, t_halted;
   logic [3:0]  w_data, t_data;
   logic [5:0]  w_ovf, t_ovf;

   perf_event_counter_bank #(.NUM_CH(5), .CNT_W(32), .SATURATE(0), .SEL_W(3)) u_dut (
      .clk(clk), .rst(rst), .ev(ev), .freeze(freeze), .clear(clear), .halt(halt),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_err(rd_err), .halted(halted), .ovf(ovf)
   );

   perf_event_counter_bank #(.NUM_CH(5), .CNT_W(4), .SATURATE(0), .SEL_W(3)) u_wrap (
      .clk(clk), .rst(s_rst), .ev(s_ev), .freeze(s_freeze), .clear(1'b0), .halt(1'b0),
      .rd_req(s_req), .rd_sel(s_sel), .rd_valid(w_valid), .rd_data(w_data),
      .rd_err(w_err), .halted(w_halted), .ovf(w_ovf)
   );

   perf_event_counter_bank #(.NUM_CH(5), .CNT_W(4), .SATURATE(1), .SEL_W(3)) u_sat (
      .clk(clk), .rst(s_rst), .ev(s_ev), .freeze(s_freeze), .clear(1'b0), .halt(1'b0),
      .rd_req(s_req), .rd_sel(s_sel), .rd_valid(t_valid), .rd_data(t_data),
      .rd_err(t_err), .halted(t_halted), .ovf(t_ovf)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single read on the main instance, then verify rd_valid drops and
   // rd_data holds even though rd_sel changes while rd_req is low.
   task automatic do_read(input string tag, input logic [2:0] sel, input logic [31:0] exp);
      rd_sel = sel;
      rd_req = 1'b1;
      tick();
      check({tag, ".valid"}, 64'(rd_valid), 64'd1);
      check({tag, ".data"}, 64'(rd_data), 64'(exp));
      check({tag, ".err"}, 64'(rd_err), 64'd0);
      rd_req = 1'b0;
      rd_sel = ~sel;
      tick();
      check({tag, ".valid_drop"}, 64'(rd_valid), 64'd0);
      check({tag, ".hold"}, 64'(rd_data), 64'(exp));
   endtask

   task automatic do_err_read(input string tag, input logic [2:0] sel);
      rd_sel = sel;
      rd_req = 1'b1;
      tick();
      check({tag, ".valid"}, 64'(rd_valid), 64'd1);
      check({tag, ".err"}, 64'(rd_err), 64'd1);
      check({tag, ".data"}, 64'(rd_data), 64'd0);
      rd_req = 1'b0;
      tick();
      check({tag, ".err_drop"}, 64'(rd_err), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; ev = '0; freeze = 1'b0; clear = 1'b0; halt = 1'b0;
      rd_req = 1'b0; rd_sel = '0;
      s_rst = 1'b0; s_ev = '0; s_freeze = 1'b1; s_req = 1'b0; s_sel = '0;
      tick();
      tick();
      check("rst.valid", 64'(rd_valid), 64'd0);
      check("rst.data", 64'(rd_data), 64'd0);
      check("rst.err", 64'(rd_err), 64'd0);
      check("rst.halted", 64'(halted), 64'd0);
      check("rst.ovf", 64'(ovf), 64'd0);
      rst = 1'b1;
      s_rst = 1'b1;

      // Basic counting: 10 cycles of ev=00011, 3 idle cycles; reads frozen.
      ev = 5'b00011;
      repeat (10) tick();
      ev = 5'b00000;
      repeat (3) tick();
      freeze = 1'b1;
      do_read("a.ch0", 3'd0, 32'd10);
      do_read("a.ch1", 3'd1, 32'd10);
      do_read("a.ch2", 3'd2, 32'd0);
      do_read("a.cyc", 3'd5, 32'd13);

      // Freeze: 4 frozen cycles ignored, 2 running cycles counted.
      ev = 5'b11111;
      repeat (4) tick();
      freeze = 1'b0;
      repeat (2) tick();
      check("b.halted", 64'(halted), 64'd0);
      freeze = 1'b1;
      ev = 5'b00000;
      // Back-to-back reads: one result per cycle.
      rd_req = 1'b1;
      rd_sel = 3'd0;
      tick();
      check("b.b2b0.valid", 64'(rd_valid), 64'd1);
      check("b.b2b0.data", 64'(rd_data), 64'd12);
      rd_sel = 3'd2;
      tick();
      check("b.b2b1.valid", 64'(rd_valid), 64'd1);
      check("b.b2b1.data", 64'(rd_data), 64'd2);
      rd_sel = 3'd5;
      tick();
      check("b.b2b2.valid", 64'(rd_valid), 64'd1);
      check("b.b2b2.data", 64'(rd_data), 64'd15);
      rd_req = 1'b0;
      tick();
      check("b.b2b.drop", 64'(rd_valid), 64'd0);

      // Halt: one running cycle, then halt with ev[4]; later events ignored.
      freeze = 1'b0;
      tick();
      ev = 5'b10000;
      halt = 1'b1;
      tick();
      check("c.halted_set", 64'(halted), 64'd1);
      halt = 1'b0;
      ev = 5'b11111;
      repeat (5) tick();
      check("c.halted_hold", 64'(halted), 64'd1);
      ev = 5'b00000;
      do_read("c.ch0", 3'd0, 32'd12);
      do_read("c.ch3", 3'd3, 32'd2);
      do_read("c.ch4", 3'd4, 32'd3);
      do_read("c.cyc", 3'd5, 32'd17);
      do_err_read("c.sel7", 3'd7);
      do_err_read("c.sel6", 3'd6);
      check("c.ovf", 64'(ovf), 64'd0);

      // Clear with ev and halt together: clear wins, events dropped.
      clear = 1'b1;
      halt = 1'b1;
      ev = 5'b11111;
      tick();
      check("d.halted", 64'(halted), 64'd0);
      clear = 1'b0;
      halt = 1'b0;
      ev = 5'b00001;
      tick();
      ev = 5'b00000;
      freeze = 1'b1;
      do_read("d.ch0", 3'd0, 32'd1);
      do_read("d.ch1", 3'd1, 32'd0);
      do_read("d.cyc", 3'd5, 32'd1);

      // 4-bit counters: 17 events on ch0 (wrap -> 1, saturate -> 15).
      s_freeze = 1'b0;
      s_ev = 5'b00001;
      repeat (17) tick();
      s_ev = 5'b00000;
      s_freeze = 1'b1;
      s_sel = 3'd0;
      s_req = 1'b1;
      tick();
      check("f.wrap.valid", 64'(w_valid), 64'd1);
      check("f.wrap.ch0", 64'(w_data), 64'd1);
      check("f.sat.valid", 64'(t_valid), 64'd1);
      check("f.sat.ch0", 64'(t_data), 64'd15);
      s_sel = 3'd5;
      tick();
      check("f.wrap.cyc", 64'(w_data), 64'd1);
      check("f.sat.cyc", 64'(t_data), 64'd15);
      s_req = 1'b0;
      repeat (3) tick();
`ifdef PERF_OVF_STICKY_EN
      check("f.wrap.ovf0", 64'(w_ovf[0]), 64'd1);
      check("f.sat.ovf0", 64'(t_ovf[0]), 64'd1);
      check("f.wrap.ovf1", 64'(w_ovf[1]), 64'd0);
`else
      check("f.wrap.ovf", 64'(w_ovf), 64'd0);
      check("f.sat.ovf", 64'(t_ovf), 64'd0);
`endif

      // Asynchronous reset during an outstanding read.
      rd_sel = 3'd0;
      rd_req = 1'b1;
      tick();
      check("e.pre.valid", 64'(rd_valid), 64'd1);
      check("e.pre.data", 64'(rd_data), 64'd1);
      rd_req = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("e.rst.valid", 64'(rd_valid), 64'd0);
      check("e.rst.data", 64'(rd_data), 64'd0);
      check("e.rst.halted", 64'(halted), 64'd0);
      tick();
      rst = 1'b1;
      do_read("e.ch0", 3'd0, 32'd0);
      do_read("e.cyc", 3'd5, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
- Synthesizable bank of per-channel event counters, parametrised in channel count and counter width.
- Replaces bench-only counting of instructions and I/D-cache requests and hits with hardware counters.
- Sits beside the pipeline and caches. Per-cycle event strobes come in; counters are read back through a registered select/read port.
- Adds freeze/clear control, freeze-on-halt, saturate-or-wrap mode and a built-in cycle counter.

Parameters:
- NUM_CH, 5, number of event channels (default map: 0 inst, 1 icache_req, 2 icache_hit, 3 dcache_req, 4 dcache_hit)
- CNT_W, 32, width of each counter and of the cycle counter
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at 2^CNT_W-1
- SEL_W, 3, width of rd_sel; must satisfy 2^SEL_W >= NUM_CH+1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ev  in  NUM_CH  per-cycle event strobes; bit i = one event on channel i this cycle
- freeze  in  1  level; while 1, no counter (including cycle) advances
- clear  in  1  one-cycle pulse; zeroes all counters, returns FSM to RUN
- halt  in  1  processor halt strobe; final-cycle events counted, then bank stops
- rd_req  in  1  read request, sampled on clk
- rd_sel  in  SEL_W  0..NUM_CH-1 = event channel; NUM_CH = cycle counter
- rd_valid  out  1  one cycle after rd_req
- rd_data  out  CNT_W  selected counter value, valid when rd_valid
- rd_err  out  1  with rd_valid when rd_sel > NUM_CH; rd_data = 0 in that case
- halted  out  1  1 while FSM in HALTED
- ovf  out  NUM_CH+1  sticky overflow flags (only with the optional feature; else tied 0)

Behaviour:
- Reset (rst=0, asynchronous): all counters 0, FSM=RUN, rd_valid=0, rd_data=0, rd_err=0, halted=0, ovf=0.
- FSM states: RUN, FROZEN, HALTED.
  - RUN -> FROZEN when freeze=1.
  - FROZEN -> RUN when freeze=0.
  - RUN or FROZEN -> HALTED on halt=1.
  - HALTED -> RUN only on clear.
  - clear from any state -> RUN.
- Precedence per cycle: clear > halt > freeze > counting.
- RUN: counter i += 1 when ev[i]=1; cycle counter += 1 every cycle.
- FROZEN: counters hold; ev ignored.
- Halt cycle in RUN: that cycle's ev and cycle tick ARE counted. From the next cycle, halted=1 and counters hold.
- Halt while freeze=1: nothing is counted that cycle; the FSM still enters HALTED.
- clear together with ev: all counters become 0; the events are dropped.
- clear together with halt: clear wins; FSM=RUN, halted=0.
- Wrap-around with SATURATE=0: 2^CNT_W-1 + 1 -> 0.
- Saturation with SATURATE=1: the counter holds at 2^CNT_W-1.
- Read port latency is 1 cycle. rd_data captures the counter value before that same edge's update (pre-increment). rd_valid deasserts the cycle after it is raised unless rd_req is held.
- Reads are accepted in every FSM state, including HALTED. Back-to-back reads give one result per cycle.
- rd_sel is sampled only when rd_req=1. rd_data holds its last value when rd_valid=0.
- Asynchronous reset mid-read: rd_valid drops immediately.

Optional Feature:
- Macro PERF_OVF_STICKY_EN.
- Defined:
  - ovf[i] sets when channel i wraps (SATURATE=0) or first reaches 2^CNT_W-1 (SATURATE=1).
  - ovf[NUM_CH] does the same for the cycle counter.
  - Flags are sticky and cleared only by clear or reset.
- Not defined: ovf is constant 0 and no overflow logic is built.

Test Plan:
- Reset, then drive ev=5'b00011 for 10 cycles and ev=0 for 3, then read sel 0, 1, 2, NUM_CH -> 10, 10, 0, 13; rd_valid exactly 1 cycle after each rd_req.
- freeze=1 for 4 cycles with ev=5'b11111, then freeze=0 for 2 cycles -> every channel +2, cycle counter +2, FSM returns to RUN.
- ev[4]=1 together with halt=1, then ev=all-1s for 5 cycles -> ch4 incremented once, halted=1 from next cycle, counters and cycle count unchanged afterwards; reads still return correct values.
- CNT_W=4, SATURATE=0, 17 events on ch0 -> reads 1; with PERF_OVF_STICKY_EN, ovf[0]=1 and stays set. Same stimulus with SATURATE=1 -> reads 15.
- clear together with ev=5'b11111 and halt=1 -> all counters 0, halted=0, FSM=RUN; next ev=5'b00001 -> ch0=1.
- rd_sel=7 with NUM_CH=5 -> rd_err=1, rd_data=0; rst pulsed low during an outstanding read -> rd_valid=0 and all counters 0 immediately.
